uart_rx_os: RTL and testbench

- 8N1-style UART receiver clocked by the system clock and paced by the 16x oversample tick from the baud generator.
- Synchronises the asynchronous rx line, validates the start bit at mid-bit, and samples data LSB-first at bit centres.
- Checks the stop bit and presents each received byte on a valid/ready interface that feeds the RX FIFO write side.
- Flags framing errors and overruns.

---
 rtl/uart_rx_os.sv | 142 ++++++++++++++
 tb/tb_uart_rx_os.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1-style UART receiver paced by a 16x oversample tick.
// A 2-flop synchroniser feeds a start/data/stop/break FSM. Completed bytes are
// presented on a valid/ready interface. Framing errors and overruns are
// reported as single-clock pulses.
module uart_rx_os #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  // The start-bit check falls on the tick that brings the count to
  // OVERSAMPLE/2, where the detection tick counts as 1. Data and stop samples
  // follow every OVERSAMPLE ticks after that check.
  localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_rx;

  assign w_rx = r_sync2;

  // Two-flop synchroniser for the asynchronous serial line. It idles high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM advances on baud ticks. The valid/ready handshake is evaluated
  // on every clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (baud_tick) begin
        case (r_state)
          S_IDLE: begin
            if (!w_rx) begin
              r_state    <= S_START;
              r_tick_cnt <= TW'(1);
            end
          end
          S_START: begin
            if (r_tick_cnt == TC_MID) begin
              if (w_rx) begin
                r_state <= S_IDLE;
              end else begin
                r_state    <= S_DATA;
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
          S_DATA: begin
            if (r_tick_cnt == TC_LAST) begin
              r_shift    <= {w_rx, r_shift[DATA_BITS-1:1]};
              r_tick_cnt <= '0;
              r_bit_cnt  <= r_bit_cnt + BW'(1);
              if (r_bit_cnt == BC_LAST) begin
                r_state <= S_STOP;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
          S_STOP: begin
            if (r_tick_cnt == TC_LAST) begin
              r_tick_cnt <= '0;
              if (w_rx) begin
                // A new byte overrides any handshake clear on the same edge.
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ready) begin
                  overrun_err <= 1'b1;
                end
                r_state <= S_IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= S_BRK;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
          S_BRK: begin
            if (w_rx) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed test of uart_rx_os with 4-clk baud ticks and 64-clk bits.
module tb_uart_rx_os;

  logic       clk;
  logic       reset;
  logic       baud_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;

  int n_vec;
  int n_err;

  // Activity recorded by the monitor. The monitor is the only writer of these.
  logic [7:0] q_bytes[$];
  int         n_ferr;
  int         n_ovr;
  time        t_last_rise;
  logic       prev_valid;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clock baud tick every fourth clock.
  initial begin
    int tcnt;
    tcnt      = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt      = tcnt + 1;
      baud_tick = ((tcnt % 4) == 0);
    end
  end

  // Monitor, sampled on the falling edge.
  initial begin
    n_ferr      = 0;
    n_ovr       = 0;
    t_last_rise = 0;
    prev_valid  = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid && !prev_valid) begin
        q_bytes.push_back(rx_data);
        t_last_rise = $time;
      end
      if (frame_err)   n_ferr = n_ferr + 1;
      if (overrun_err) n_ovr  = n_ovr + 1;
      prev_valid = rx_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (64 * n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
  endtask

  initial begin
    int   qb;
    int   fb;
    int   ob;
    time  t0;
    int   lat;
    logic got;

    n_vec    = 0;
    n_err    = 0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    reset    = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data",  rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr",  frame_err, 0);
    chk("rst_ovr",   overrun_err, 0);
    reset = 1'b1;
    idle_bits(2);

    // Single 0xA5 frame with a latency check.
    qb = q_bytes.size(); fb = n_ferr; ob = n_ovr;
    t0 = $time;
    send(8'hA5, 1'b1);
    idle_bits(2);
    chk("a5_count", q_bytes.size() - qb, 1);
    if (q_bytes.size() > qb) chk("a5_data", q_bytes[qb], 8'hA5);
    chk("a5_ferr", n_ferr - fb, 0);
    chk("a5_ovr",  n_ovr - ob, 0);
    lat = int'((t_last_rise - t0) / 10);
    chk("a5_latency_in_600_616", (lat >= 600 && lat <= 616), 1);

    // False start followed by a good 0x3C frame.
    qb = q_bytes.size(); fb = n_ferr;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    idle_bits(2);
    chk("false_count", q_bytes.size() - qb, 0);
    chk("false_ferr",  n_ferr - fb, 0);
    send(8'h3C, 1'b1);
    idle_bits(2);
    chk("3c_count", q_bytes.size() - qb, 1);
    if (q_bytes.size() > qb) chk("3c_data", q_bytes[qb], 8'h3C);

    // 0x55 with a low stop bit and a long break, then 0x81.
    qb = q_bytes.size(); fb = n_ferr;
    send(8'h55, 1'b0);
    rx = 1'b0;
    repeat (64 * 30) @(negedge clk);
    idle_bits(2);
    chk("brk_ferr",  n_ferr - fb, 1);
    chk("brk_count", q_bytes.size() - qb, 0);
    send(8'h81, 1'b1);
    idle_bits(2);
    chk("81_count", q_bytes.size() - qb, 1);
    if (q_bytes.size() > qb) chk("81_data", q_bytes[qb], 8'h81);
    chk("81_ferr", n_ferr - fb, 1);

    // Overrun with rx_ready held low.
    qb = q_bytes.size(); ob = n_ovr;
    rx_ready = 1'b0;
    send(8'h11, 1'b1);
    idle_bits(1);
    chk("ovr_v1",    rx_valid, 1);
    chk("ovr_d1",    rx_data, 8'h11);
    chk("ovr_none1", n_ovr - ob, 0);
    send(8'h22, 1'b1);
    idle_bits(1);
    chk("ovr_pulse", n_ovr - ob, 1);
    chk("ovr_d2",    rx_data, 8'h22);
    chk("ovr_v2",    rx_valid, 1);
    chk("ovr_rises", q_bytes.size() - qb, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_clear", rx_valid, 0);

    // Reset while the high data bits of 0xF0 are on the line.
    qb = q_bytes.size(); fb = n_ferr;
    fork
      send(8'hF0, 1'b1);
      begin
        repeat (64 * 5 + 32) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_data",  rx_data, 8'h00);
        chk("mrst_valid", rx_valid, 0);
        chk("mrst_ferr",  frame_err, 0);
        chk("mrst_ovr",   overrun_err, 0);
        @(negedge clk);
        reset = 1'b1;
      end
    join
    idle_bits(2);
    chk("mrst_count", q_bytes.size() - qb, 0);
    send(8'h0F, 1'b1);
    idle_bits(2);
    chk("0f_count", q_bytes.size() - qb, 1);
    if (q_bytes.size() > qb) chk("0f_data", q_bytes[qb], 8'h0F);
    chk("0f_ferr", n_ferr - fb, 0);

    // Back-to-back 0x00 and 0xFF, ready pulsed once on the first byte.
    qb = q_bytes.size(); fb = n_ferr; ob = n_ovr;
    rx_ready = 1'b0;
    got = 1'b0;
    fork
      begin
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        idle_bits(2);
      end
      begin
        for (int i = 0; i < 1500 && !got; i++) begin
          @(negedge clk);
          if (rx_valid) got = 1'b1;
        end
        if (got) begin
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
        end
      end
    join
    chk("b2b_hs",    got, 1);
    chk("b2b_count", q_bytes.size() - qb, 2);
    if (q_bytes.size() > qb + 1) begin
      chk("b2b_d0", q_bytes[qb], 8'h00);
      chk("b2b_d1", q_bytes[qb + 1], 8'hFF);
    end
    chk("b2b_valid", rx_valid, 1);
    chk("b2b_data",  rx_data, 8'hFF);
    chk("b2b_ferr",  n_ferr - fb, 0);
    chk("b2b_ovr",   n_ovr - ob, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
